// File: rtl/mem_pkg.sv
// Shared types and width helpers for the burst main memory.
// Covers the FSM state encoding and widths derived from the module parameters.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int line_width(input int data_width, input int words_per_line);
        return data_width * words_per_line;
    endfunction

    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int count_width(input int latency);
        return $clog2(latency);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage with one byte-enabled write port and a full line of combinational read ports.
// With MEM_ZERO_ON_RESET_EN defined, reset clears every word; otherwise contents survive reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                    clk,
`ifdef MEM_ZERO_ON_RESET_EN
    input  logic                                    reset_n,
`endif
    input  logic                                    we,
    input  logic [ADDR_WIDTH-1:0]                   waddr,
    input  logic [DATA_WIDTH-1:0]                   wdata,
    input  logic [DATA_WIDTH/8-1:0]                 wbe,
    input  logic [ADDR_WIDTH-offset_width(WORDS_PER_LINE)-1:0] line_addr,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0]    rdata
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int OFF_W  = offset_width(WORDS_PER_LINE);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_ZERO_ON_RESET_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`endif

    // Word i of the line sits at the aligned base with offset i.
    for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_rd
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[{line_addr, OFF_W'(i)}];
    end

endmodule

// File: rtl/burst_main_memory.sv
// Fixed-latency main memory: line reads, byte-enabled word writes, one-cycle ready pulse.
// Optional MEM_ZERO_ON_RESET_EN makes reset clear the storage array.
module burst_main_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 read,
    input  logic                                 write,
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [DATA_WIDTH/8-1:0]              byte_en,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rline,
    output logic                                 ready,
    output logic                                 busy
);

    localparam int LINE_W = line_width(DATA_WIDTH, WORDS_PER_LINE);
    localparam int OFF_W  = offset_width(WORDS_PER_LINE);
    localparam int CNT_W  = count_width(LATENCY);
    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LATENCY - 2);

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [NBYTES-1:0]     lat_be;
    logic [LINE_W-1:0]     line_data;
    logic                  accept;
    logic                  commit;
    logic                  capture;

    assign accept  = (state == IDLE) && (read || write);
    assign commit  = (state == WR_WAIT) && (count == LAST_COUNT);
    assign capture = (state == RD_WAIT) && (count == LAST_COUNT);

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (read) begin
                    next_state = RD_WAIT;
                end else if (write) begin
                    next_state = WR_WAIT;
                end
            end
            RD_WAIT: if (count == LAST_COUNT) next_state = DONE;
            WR_WAIT: if (count == LAST_COUNT) next_state = DONE;
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured only on acceptance, so inputs are ignored while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rline     <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                count     <= '0;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_be    <= byte_en;
            end else if (state == RD_WAIT || state == WR_WAIT) begin
                count <= count + CNT_W'(1);
            end
            if (capture) begin
                rline <= line_data;
            end
        end
    end

    mem_word_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk       (clk),
`ifdef MEM_ZERO_ON_RESET_EN
        .reset_n   (reset_n),
`endif
        .we        (commit),
        .waddr     (lat_addr),
        .wdata     (lat_wdata),
        .wbe       (lat_be),
        .line_addr (lat_addr[ADDR_WIDTH-1:OFF_W]),
        .rdata     (line_data)
    );

endmodule
